uart_rx_cp: RTL and testbench

UART receive engine for the D9 UART block, the receive-side counterpart of the transmit control path. It samples the asynchronous serial input `rx` and frames 8N1 characters (1 start, 8 data LSB-first, 1 stop). Bit timing comes from an internal counter driven by the shared `baud` divisor (clock cycles per bit). Each received byte is presented on `dout` with a one-cycle `rx_valid` strobe.

---
 rtl/uart_rx_cp.sv | 137 +++++++++++++
 tb/tb_uart_rx_cp.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cp.sv
// uart_rx_cp: 8N1 UART receive engine for the D9 UART block.
// Mid-bit sampling off a per-frame latched baud divisor.
module uart_rx_cp #(
   parameter int DATA_BITS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel,
   input  logic [19:0] baud,
   input  logic        rx,
   output logic [7:0]  dout,
   output logic        rx_valid,
   output logic        frame_err,
   output logic        rx_busy,
   output logic [3:0]  bit_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t      state;
   logic        rx_m;
   logic        rx_s;
   logic        rx_d;
   logic [19:0] cnt;
   logic [19:0] baud_l;
   logic [19:0] half;
   logic [7:0]  shift;
   logic        valid_baud;
   logic        fall;
   logic        run;
   logic        bit_end;
   logic        half_end;

   assign valid_baud = (baud >= 20'd15);
   assign run        = sel & valid_baud;
   assign fall       = rx_d & ~rx_s;
   assign half       = baud_l >> 1;
   assign half_end   = (cnt == half - 20'd1);
   assign bit_end    = (cnt == baud_l - 20'd1);

   // Two-flop synchronizer plus one delay stage for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         baud_l    <= '0;
         shift     <= '0;
         dout      <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         rx_busy   <= 1'b0;
         bit_cnt   <= '0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         if (!run) begin
            state   <= IDLE;
            cnt     <= '0;
            rx_busy <= 1'b0;
            bit_cnt <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (fall) begin
                     state   <= START;
                     baud_l  <= baud;
                     cnt     <= '0;
                     bit_cnt <= '0;
                     rx_busy <= 1'b1;
                  end
               end
               START: begin
                  if (half_end) begin
                     cnt <= '0;
                     if (!rx_s) begin
                        state   <= DATA;
                        bit_cnt <= 4'd1;
                     end else begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                     end
                  end else begin
                     cnt <= cnt + 20'd1;
                  end
               end
               DATA: begin
                  if (bit_end) begin
                     cnt     <= '0;
                     shift   <= {rx_s, shift[7:1]};
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'(DATA_BITS))
                        state <= STOP;
                  end else begin
                     cnt <= cnt + 20'd1;
                  end
               end
               STOP: begin
                  if (bit_end) begin
                     // Back to IDLE at mid-stop so the next start edge is caught
                     cnt     <= '0;
                     state   <= IDLE;
                     rx_busy <= 1'b0;
                     bit_cnt <= '0;
                     if (rx_s) begin
                        dout     <= shift;
                        rx_valid <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 20'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_cp.sv
// tb_uart_rx_cp: directed frames against uart_rx_cp.
// Expected bytes, pulse counts and latencies are hand-computed.
module tb_uart_rx_cp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b1;
   logic [19:0] baud = 20'd16;
   logic        rx = 1'b1;
   logic [7:0]  dout;
   logic        rx_valid;
   logic        frame_err;
   logic        rx_busy;
   logic [3:0]  bit_cnt;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int bd = 16;
   int t_start = 0;
   int nvalid = 0;
   int nferr = 0;
   int nboth = 0;
   int nbusy = 0;
   int vcyc = 0;
   logic [7:0] vdout = 8'h00;
   int v0;
   int b0;

   uart_rx_cp dut (
      .clk       (clk),
      .rst       (rst),
      .sel       (sel),
      .baud      (baud),
      .rx        (rx),
      .dout      (dout),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .rx_busy   (rx_busy),
      .bit_cnt   (bit_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid) begin
         nvalid = nvalid + 1;
         vdout  = dout;
         vcyc   = cyc;
      end
      if (frame_err) nferr = nferr + 1;
      if (rx_valid && frame_err) nboth = nboth + 1;
      if (rx_busy) nbusy = nbusy + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic wait_bit();
      repeat (bd) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the stop bit
   task automatic send(input logic [7:0] d, input logic stopv);
      t_start = cyc;
      rx = 1'b0;
      wait_bit();
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         wait_bit();
      end
      rx = stopv;
      wait_bit();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_dout", dout, 8'h00);
      check("rst_valid", rx_valid, 1'b0);
      check("rst_ferr", frame_err, 1'b0);
      check("rst_busy", rx_busy, 1'b0);
      check("rst_bitcnt", bit_cnt, 4'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Back-to-back frames at baud 16: latency 3 + 8 + 144
      send(8'h55, 1'b1);
      check("b2b1_cnt", nvalid, 1);
      check("b2b1_dout", vdout, 8'h55);
      check("b2b1_lat", vcyc - t_start, 155);
      send(8'hA3, 1'b1);
      check("b2b2_cnt", nvalid, 2);
      check("b2b2_dout", vdout, 8'hA3);
      check("b2b2_lat", vcyc - t_start, 155);
      check("b2b_ferr", nferr, 0);

      // Framing error, then break, then recovery
      send(8'h3C, 1'b0);
      check("ferr_cnt", nferr, 1);
      check("ferr_novalid", nvalid, 2);
      check("ferr_dout", dout, 8'hA3);
      b0 = nbusy;
      repeat (40) wait_bit();
      check("break_busy", nbusy - b0, 0);
      check("break_ferr", nferr, 1);
      rx = 1'b1;
      repeat (2) wait_bit();
      send(8'h81, 1'b1);
      check("rec_cnt", nvalid, 3);
      check("rec_dout", vdout, 8'h81);

      // 3-cycle glitch: busy exactly half = 8 cycles
      b0 = nbusy;
      rx = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("glitch_busy", nbusy - b0, 8);
      check("glitch_valid", nvalid, 3);
      check("glitch_ferr", nferr, 1);

      // Invalid baud 14 ignored, 15 accepted (half 7)
      bd = 14;
      baud = 20'd14;
      b0 = nbusy;
      send(8'hFF, 1'b1);
      wait_bit();
      check("b14_busy", nbusy - b0, 0);
      check("b14_valid", nvalid, 3);
      bd = 15;
      baud = 20'd15;
      wait_bit();
      send(8'hFF, 1'b1);
      check("b15_cnt", nvalid, 4);
      check("b15_dout", vdout, 8'hFF);
      check("b15_lat", vcyc - t_start, 145);

      // sel dropped during data bit 4
      bd = 20;
      baud = 20'd20;
      wait_bit();
      v0 = nvalid;
      fork
         send(8'h12, 1'b1);
         begin
            repeat (110) @(posedge clk);
            #2;
            sel = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check("seloff_busy", rx_busy, 1'b0);
         end
      join
      check("seloff_valid", nvalid, v0);
      sel = 1'b1;
      wait_bit();
      send(8'h12, 1'b1);
      check("selon_cnt", nvalid, v0 + 1);
      check("selon_dout", vdout, 8'h12);

      // Async reset during data bit 2
      bd = 16;
      baud = 20'd16;
      wait_bit();
      fork
         send(8'h5A, 1'b1);
         begin
            repeat (56) @(posedge clk);
            #2;
            check("pre_rst_busy", rx_busy, 1'b1);
            rst = 1'b1;
            #1;
            check("arst_dout", dout, 8'h00);
            check("arst_bitcnt", bit_cnt, 4'd0);
            check("arst_busy", rx_busy, 1'b0);
         end
      join
      check("arst_dout_hold", dout, 8'h00);
      rst = 1'b0;
      v0 = nvalid;
      wait_bit();
      send(8'h7E, 1'b1);
      check("post_rst_cnt", nvalid, v0 + 1);
      check("post_rst_dout", vdout, 8'h7E);
      check("post_rst_lat", vcyc - t_start, 155);

      wait_bit();
      check("never_both", nboth, 0);
      check("ferr_total", nferr, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
